// File: rtl/register_read_pkg.sv
// register_read_pkg: shared processor constants for operand read and writeback.
package register_read_pkg;
   localparam int ADDR_W = 3;
   typedef enum logic [1:0] {
      OP1_LOAD   = 2'd0,
      OP1_STORE  = 2'd1,
      OP1_BRANCH = 2'd2,
      OP1_ALU    = 2'd3
   } op1_t;
   // Loads and branches only consume operand B; operand A is forced to zero.
   function automatic logic reads_a(input logic [1:0] op);
      return !(op == OP1_LOAD || op == OP1_BRANCH);
   endfunction
endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: register array with one synchronous write port and two async read ports.
module regfile_8x16
   import register_read_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra_a,
   input  logic [ADDR_W-1:0] ra_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);
   logic [DATA_W-1:0] regs [NREG];
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n)
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      else if (we)
         regs[wa] <= wd;
   assign rd_a = regs[ra_a];
   assign rd_b = regs[ra_b];
endmodule

// File: rtl/register_read.sv
// register_read: operand fetch stage with write bypass, stall hold and in-place
// refresh of held operands.
module register_read
   import register_read_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        op1,
   input  logic [ADDR_W-1:0] Ra_op2,
   input  logic [ADDR_W-1:0] Rd_Rb,
   input  logic              issue,
   input  logic              stall,
   input  logic [ADDR_W-1:0] write_add,
   input  logic              writeOrder,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] ar,
   output logic [DATA_W-1:0] br,
   output logic              operand_valid,
   output logic [ADDR_W-1:0] read_add_a,
   output logic [ADDR_W-1:0] read_add_b
);
   logic [DATA_W-1:0] rd_a, rd_b, cap_a, cap_b;
   logic              a_used;

   regfile_8x16 #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (writeOrder),
      .wa      (write_add),
      .wd      (write_data),
      .ra_a    (Ra_op2),
      .ra_b    (Rd_Rb),
      .rd_a    (rd_a),
      .rd_b    (rd_b)
   );

   assign cap_a = !reads_a(op1) ? '0 :
                  (writeOrder && write_add == Ra_op2) ? write_data : rd_a;
   assign cap_b = (writeOrder && write_add == Rd_Rb) ? write_data : rd_b;

   // a_used remembers whether ar is a real operand, so refresh never un-masks it.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         ar            <= '0;
         br            <= '0;
         read_add_a    <= '0;
         read_add_b    <= '0;
         operand_valid <= 1'b0;
         a_used        <= 1'b0;
      end else if (!stall) begin
         if (issue) begin
            ar         <= cap_a;
            br         <= cap_b;
            read_add_a <= Ra_op2;
            read_add_b <= Rd_Rb;
            a_used     <= reads_a(op1);
         end
         operand_valid <= issue;
      end else if (operand_valid && writeOrder) begin
         if (a_used && write_add == read_add_a) ar <= write_data;
         if (write_add == read_add_b) br <= write_data;
      end
endmodule

// File: tb/tb_register_read.sv
// tb_register_read: randomized and directed checks of register_read against a
// behavioural register-file and operand model.
module tb_register_read;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  op1 = '0;
   logic [2:0]  Ra_op2 = '0, Rd_Rb = '0, write_add = '0;
   logic        issue = 1'b0, stall = 1'b0, writeOrder = 1'b0;
   logic [15:0] write_data = '0;
   logic [15:0] ar, br;
   logic        operand_valid;
   logic [2:0]  read_add_a, read_add_b;

   int errs = 0, checks = 0;

   logic [15:0] m_regs [8];
   logic [15:0] m_ar, m_br;
   logic [2:0]  m_aa, m_ab;
   logic        m_va, m_a_live;

   register_read dut (
      .clock(clock), .reset_n(reset_n), .op1(op1), .Ra_op2(Ra_op2), .Rd_Rb(Rd_Rb),
      .issue(issue), .stall(stall), .write_add(write_add), .writeOrder(writeOrder),
      .write_data(write_data), .ar(ar), .br(br), .operand_valid(operand_valid),
      .read_add_a(read_add_a), .read_add_b(read_add_b)
   );

   always #5 clock = ~clock;

   task automatic m_clear();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_ar = '0; m_br = '0; m_aa = '0; m_ab = '0; m_va = 1'b0; m_a_live = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model on the edge, return at edge+1.
   task automatic cycle(input logic [1:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic iss, input logic stl, input logic we,
                        input logic [2:0] wa, input logic [15:0] wd);
      op1 = op; Ra_op2 = ra; Rd_Rb = rb; issue = iss; stall = stl;
      writeOrder = we; write_add = wa; write_data = wd;
      @(posedge clock);
      if (!stl && iss) begin
         m_a_live = !(op == 2'd0 || op == 2'd2);
         m_ar = !m_a_live ? 16'h0 : (we && wa == ra) ? wd : m_regs[ra];
         m_br = (we && wa == rb) ? wd : m_regs[rb];
         m_aa = ra; m_ab = rb; m_va = 1'b1;
      end else if (!stl) begin
         m_va = 1'b0;
      end else if (m_va && we) begin
         if (m_a_live && wa == m_aa) m_ar = wd;
         if (wa == m_ab) m_br = wd;
      end
      if (we) m_regs[wa] = wd;
      #1;
   endtask

   task automatic test_reset();
      m_clear();
      #1;
      checks++;
      if ({ar, br, operand_valid, read_add_a, read_add_b} !== 39'h0) begin
         errs++; $display("FAIL reset_initial: got %h %h %b %0d %0d required all zero", ar, br, operand_valid, read_add_a, read_add_b);
      end
      #2 reset_n = 1'b1;
      cycle(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 16'hA5A5);
      cycle(2'd3, 3'd6, 3'd7, 1'b1, 1'b0, 1'b1, 3'd7, 16'h5A5A);
      cycle(2'd3, 3'd6, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
      reset_n = 1'b0;
      #2;
      checks++;
      if ({ar, br, operand_valid, read_add_a, read_add_b} !== 39'h0) begin
         errs++; $display("FAIL reset_async: got %h %h %b %0d %0d required all zero", ar, br, operand_valid, read_add_a, read_add_b);
      end
      m_clear();
      #2 reset_n = 1'b1;
      cycle(2'd3, 3'd6, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
      checks++;
      if (operand_valid !== 1'b0 || br !== 16'h0) begin
         errs++; $display("FAIL reset_stall_discard: got valid=%b br=%h required 0 0000", operand_valid, br);
      end
      cycle(2'd3, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (ar !== 16'h0 || br !== 16'h0 || operand_valid !== 1'b1) begin
         errs++; $display("FAIL reset_first_issue: got ar=%h br=%h v=%b required 0000 0000 1", ar, br, operand_valid);
      end
   endtask

   task automatic test_basic_read();
      cycle(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234);
      cycle(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h00FF);
      cycle(2'd3, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (ar !== 16'h1234 || br !== 16'h00FF || operand_valid !== 1'b1) begin
         errs++; $display("FAIL basic_read: got ar=%h br=%h v=%b required 1234 00ff 1", ar, br, operand_valid);
      end
      checks++;
      if (read_add_a !== 3'd3 || read_add_b !== 3'd5) begin
         errs++; $display("FAIL basic_addr: got %0d %0d required 3 5", read_add_a, read_add_b);
      end
   endtask

   task automatic test_bypass();
      cycle(2'd3, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1, 3'd2, 16'hBEEF);
      checks++;
      if (ar !== 16'hBEEF || br !== 16'hBEEF) begin
         errs++; $display("FAIL bypass: got ar=%h br=%h required beef beef", ar, br);
      end
   endtask

   task automatic test_stall_refresh();
      cycle(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0011);
      cycle(2'd3, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (br !== 16'h0011) begin
         errs++; $display("FAIL stall_capture: got br=%h required 0011", br);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(2'(i), 3'(i + 5), 3'(i), 1'(i % 2), 1'b1, i == 1, 3'd4, 16'h0022);
         checks++;
         if (br !== (i == 0 ? 16'h0011 : 16'h0022) || ar !== 16'h1234 || operand_valid !== 1'b1 || read_add_b !== 3'd4) begin
            errs++; $display("FAIL stall_hold_%0d: got ar=%h br=%h v=%b rb=%0d required 1234 %h 1 4", i, ar, br, operand_valid, read_add_b, i == 0 ? 16'h0011 : 16'h0022);
         end
      end
   endtask

   task automatic test_mask_bubble();
      cycle(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h7777);
      cycle(2'd0, 3'd1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (ar !== 16'h0 || br !== 16'h0022) begin
         errs++; $display("FAIL mask_load: got ar=%h br=%h required 0000 0022", ar, br);
      end
      cycle(2'd3, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      checks++;
      if (operand_valid !== 1'b0 || ar !== 16'h0 || br !== 16'h0022) begin
         errs++; $display("FAIL bubble: got v=%b ar=%h br=%h required 0 0000 0022", operand_valid, ar, br);
      end
      cycle(2'd2, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      cycle(2'd2, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 16'h9999);
      checks++;
      if (ar !== 16'h0 || br !== 16'h1234) begin
         errs++; $display("FAIL mask_refresh: got ar=%h br=%h required 0000 1234", ar, br);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cycle(2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
         checks++;
         if ({ar, br, operand_valid, read_add_a, read_add_b} !== {m_ar, m_br, m_va, m_aa, m_ab}) begin
            errs++; $display("FAIL random_%0d: got %h %h %b %0d %0d required %h %h %b %0d %0d", n, ar, br, operand_valid, read_add_a, read_add_b, m_ar, m_br, m_va, m_aa, m_ab);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_bypass();
      test_stall_refresh();
      test_mask_bubble();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
